// File: rtl/mult_rr_sched.sv
// mult_rr_sched: four-requester round-robin front end for a single
// sequential shift-add multiplier. One operand bit is processed per clock,
// so a product takes w cycles after the grant edge, and the block then
// returns to IDLE for one arbitration edge.
module mult_rr_sched #(
  parameter int w = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [3:0]       req,
  input  logic [4*w-1:0]   a,
  input  logic [4*w-1:0]   b,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       owner,
  output logic [2*w-1:0]   out
);

  localparam int CW = (w > 1) ? $clog2(w) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [w-1:0]     a_q, a_d;
  logic [w-1:0]     b_q, b_d;
  logic [2*w-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       owner_q, owner_d;
  logic [2*w-1:0]   out_q, out_d;

  logic             arb_found_s;
  logic [1:0]       arb_win_s;
  logic [2*w-1:0]   pp_s;
  logic [2*w-1:0]   acc_sum_s;

  // Round-robin search: first raised request starting at ptr, wrapping mod 4.
  always_comb begin
    arb_found_s = 1'b0;
    arb_win_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!arb_found_s && req[ptr_q + 2'(k)]) begin
        arb_found_s = 1'b1;
        arb_win_s   = ptr_q + 2'(k);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (b_q[cnt_q]) begin
      pp_s = {{w{1'b0}}, a_q} << cnt_q;
    end else begin
      pp_s = {(2*w){1'b0}};
    end
    acc_sum_s = acc_q + pp_s;
  end

  // Next-state and registered-output logic for the IDLE/CALC controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    owner_d = owner_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (arb_found_s) begin
          state_d = CALC;
          win_d   = arb_win_s;
          a_d     = a[arb_win_s*w +: w];
          b_d     = b[arb_win_s*w +: w];
          gnt_d   = 4'b0001 << arb_win_s;
          busy_d  = 1'b1;
          acc_d   = {(2*w){1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(w - 1)) begin
          out_d   = acc_sum_s;
          owner_d = win_q;
          done_d  = 1'b1;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = win_q + 2'd1;
          state_d = IDLE;
        end else begin
          state_d = CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any running operation at once.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      a_q     <= {w{1'b0}};
      b_q     <= {w{1'b0}};
      acc_q   <= {(2*w){1'b0}};
      cnt_q   <= {CW{1'b0}};
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= 2'd0;
      out_q   <= {(2*w){1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      out_q   <= out_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Testbench for mult_rr_sched: directed plan steps plus randomized traffic,
// checked against a transaction-level model (round-robin pick + a*b).
module tb_mult_rr_sched;

  logic        clk = 1'b0;
  logic        rst_b;

  logic [3:0]  req4;
  logic [15:0] a4, b4;
  logic [3:0]  gnt4;
  logic        busy4, done4;
  logic [1:0]  owner4;
  logic [7:0]  out4;

  logic [3:0]  req6;
  logic [23:0] a6, b6;
  logic [3:0]  gnt6;
  logic        busy6, done6;
  logic [1:0]  owner6;
  logic [11:0] out6;

  int vectors = 0;
  int errors  = 0;
  int mptr4   = 0;
  int mptr6   = 0;

  mult_rr_sched #(.w(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .req(req4), .a(a4), .b(b4),
    .gnt(gnt4), .busy(busy4), .done(done4), .owner(owner4), .out(out4)
  );

  mult_rr_sched #(.w(6)) dut6 (
    .clk(clk), .rst_b(rst_b), .req(req6), .a(a6), .b(b6),
    .gnt(gnt6), .busy(busy6), .done(done6), .owner(owner6), .out(out6)
  );

  always #5 clk = ~clk;

  // Safety net in case the sequence stalls.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first raised request searching p, p+1, p+2, p+3 mod 4.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One full w=4 transaction starting at the next (arbitration) edge.
  task automatic op4(input logic [3:0] req_mid, input bit scramble,
                     output int o_owner, output int o_out);
    int win;
    int expv;
    win = pick(req4, mptr4);
    if (win < 0) begin
      chk("op4_no_request", 32'd0, 32'd1);
      win = 0;
    end
    expv = a4[win*4 +: 4] * b4[win*4 +: 4];
    tick();
    chk("gnt_e0", gnt4, 32'(1 << win));
    chk("busy_e0", busy4, 32'd1);
    chk("done_e0", done4, 32'd0);
    req4 = req_mid;
    if (scramble) begin
      a4 = 16'($urandom);
      b4 = 16'($urandom);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("gnt_hold", gnt4, 32'(1 << win));
      chk("done_early", done4, 32'd0);
    end
    tick();
    chk("done_pulse", done4, 32'd1);
    chk("product", out4, 32'(expv));
    chk("owner", owner4, 32'(win));
    chk("gnt_release", gnt4, 32'd0);
    chk("busy_release", busy4, 32'd0);
    o_owner = owner4;
    o_out   = out4;
    mptr4   = (win + 1) % 4;
    req4[win] = 1'b0;
  endtask

  // One full w=6 transaction starting at the next (arbitration) edge.
  task automatic op6(output int o_out);
    int win;
    int expv;
    win = pick(req6, mptr6);
    if (win < 0) begin
      chk("op6_no_request", 32'd0, 32'd1);
      win = 0;
    end
    expv = a6[win*6 +: 6] * b6[win*6 +: 6];
    tick();
    chk("w6_gnt_e0", gnt6, 32'(1 << win));
    a6 = 24'($urandom);
    b6 = 24'($urandom);
    for (int c = 1; c < 6; c++) begin
      tick();
      chk("w6_done_early", done6, 32'd0);
    end
    tick();
    chk("w6_done_pulse", done6, 32'd1);
    chk("w6_product", out6, 32'(expv));
    chk("w6_owner", owner6, 32'(win));
    o_out = out6;
    mptr6 = (win + 1) % 4;
    req6[win] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt4, 32'd0);
    chk({tag, "_busy"}, busy4, 32'd0);
    chk({tag, "_done"}, done4, 32'd0);
    chk({tag, "_owner"}, owner4, 32'd0);
    chk({tag, "_out"}, out4, 32'd0);
    chk({tag, "_out6"}, out6, 32'd0);
    chk({tag, "_busy6"}, busy6, 32'd0);
  endtask

  initial begin
    int ow;
    int pv;
    int exp_own[7];
    int exp_prod[4];
    exp_own  = '{0, 2, 0, 2, 0, 1, 2};
    exp_prod = '{12, 14, 225, 0};
    rst_b = 1'b0;
    req4 = 4'b0000; a4 = 16'd0; b4 = 16'd0;
    req6 = 4'b0000; a6 = 24'd0; b6 = 24'd0;

    // Reset held for two cycles.
    tick();
    tick();
    check_reset_outputs("reset");
    rst_b = 1'b1;
    mptr4 = 0;
    mptr6 = 0;

    // Single request 5*10, operands disturbed and req dropped after the grant.
    req4 = 4'b0001;
    a4 = 16'h0005;
    b4 = 16'h000A;
    op4(4'b0000, 1'b1, ow, pv);
    chk("single_out", 32'(pv), 32'd50);
    chk("single_owner", 32'(ow), 32'd0);
    tick();
    chk("single_done_fall", done4, 32'd0);
    chk("idle_out_hold", out4, 32'd50);

    // Fresh reset, then all four requesters at once.
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    mptr4 = 0;
    req4 = 4'b1111;
    a4 = 16'h6F23;
    b4 = 16'h0F74;
    for (int i = 0; i < 4; i++) begin
      op4(req4, 1'b0, ow, pv);
      chk("all4_owner", 32'(ow), 32'(i));
      chk("all4_out", 32'(pv), 32'(exp_prod[i]));
    end
    tick();
    chk("all4_done_fall", done4, 32'd0);

    // Fairness: req0 and req2 continuously, req1 raised during requester 2's operation.
    for (int i = 0; i < 7; i++) begin
      req4 = req4 | 4'b0101;
      a4 = 16'($urandom);
      b4 = 16'($urandom);
      op4((i == 3) ? (req4 | 4'b0010) : req4, 1'b1, ow, pv);
      chk("fair_owner", 32'(ow), 32'(exp_own[i]));
    end
    req4 = 4'b0000;
    tick();
    chk("fair_idle_busy", busy4, 32'd0);

    // Asynchronous reset in the middle of an operation.
    req4 = 4'b0001;
    a4 = 16'h000F;
    b4 = 16'h000F;
    tick();
    tick();
    tick();
    req4 = 4'b0000;
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_outputs("midcalc_reset");
    tick();
    tick();
    rst_b = 1'b1;
    mptr4 = 0;
    mptr6 = 0;
    tick();
    chk("post_reset_done", done4, 32'd0);
    chk("post_reset_busy", busy4, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 20; i++) begin
      req4 = 4'($urandom_range(1, 15));
      a4 = 16'($urandom);
      b4 = 16'($urandom);
      op4(4'($urandom) | req4, 1'b1, ow, pv);
    end
    req4 = 4'b0000;
    tick();
    chk("rand_done_fall", done4, 32'd0);

    // Width w=6.
    req6 = 4'b0001;
    a6 = 24'd63;
    b6 = 24'd63;
    op6(pv);
    chk("w6_63x63", 32'(pv), 32'd3969);
    req6 = 4'b0010;
    a6 = 24'd13 << 6;
    b6 = 24'd63 << 6;
    op6(pv);
    chk("w6_13x63", 32'(pv), 32'd819);
    for (int i = 0; i < 4; i++) begin
      req6 = 4'($urandom_range(1, 15));
      a6 = 24'($urandom);
      b6 = 24'($urandom);
      op6(pv);
    end
    req6 = 4'b0000;
    tick();
    chk("w6_done_fall", done6, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
